axis_chirp_sequencer: RTL and testbench

//  Sequences axis_chirp_framer: drives its ramp input with a programmed burst of chirps (ramp-high
//  for RAMP_LEN cycles, ramp-low for IDLE_LEN cycles, NCHIRPS times) and latches cfg_nfft for it.

---
 rtl/axis_chirp_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_axis_chirp_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_chirp_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : axis_chirp_sequencer                                         |
// | Description: Drives a chirp framer's ramp input with a programmed burst   |
// |              of chirps, latches the FFT size and audits returned frames.  |
// |              Optional macro CHIRP_SEQ_CONTINUOUS_EN enables free-running  |
// |              bursts when cfg_nchirps is zero.                             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module axis_chirp_sequencer #(
    parameter int CNT_WIDTH = 24,
    parameter int NCH_WIDTH = 16,
    parameter int DRAIN_MAX = 4096
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] cfg_ramp_len,
    input  logic [CNT_WIDTH-1:0] cfg_idle_len,
    input  logic [NCH_WIDTH-1:0] cfg_nchirps,
    input  logic [4:0]           cfg_nfft_in,
    output logic [4:0]           cfg_nfft,
    input  logic                 err_nsmall,
    output logic                 ramp,
    input  logic                 f_tvalid,
    input  logic                 f_tready,
    input  logic                 f_tlast,
    output logic                 busy,
    output logic                 done,
    output logic [NCH_WIDTH-1:0] chirp_idx,
    output logic [NCH_WIDTH-1:0] frames,
    output logic                 err_cfg,
    output logic                 err_frames
);

    localparam int       c_drain_w = $clog2(DRAIN_MAX + 1);
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_ramp  = 2'd1;
    localparam logic [1:0] c_gap   = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;

    logic [1:0]           state_q,      state_d;
    logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;
    logic [c_drain_w-1:0] drain_cnt_q,  drain_cnt_d;
    logic [CNT_WIDTH-1:0] ramp_len_q,   ramp_len_d;
    logic [CNT_WIDTH-1:0] idle_len_q,   idle_len_d;
    logic [NCH_WIDTH-1:0] nchirps_q,    nchirps_d;
    logic [4:0]           nfft_q,       nfft_d;
    logic [NCH_WIDTH-1:0] chirp_idx_q,  chirp_idx_d;
    logic [NCH_WIDTH-1:0] frames_q,     frames_d;
    logic                 err_cfg_q,    err_cfg_d;
    logic                 err_frames_q, err_frames_d;
    logic                 done_q,       done_d;
    logic                 nsmall_q,     nsmall_d;

    logic                 w_nch_ok;
    logic                 w_cfg_ok;
    logic                 w_last_chirp;
    logic [NCH_WIDTH:0]   w_issued;
    logic                 w_hs;
    logic                 w_cnt_end;
    logic                 w_drain_exit;
    logic                 w_busy;

`ifdef CHIRP_SEQ_CONTINUOUS_EN
    // Zero chirps selects free-running mode: never reach the last chirp.
    assign w_nch_ok     = 1'b1;
    assign w_last_chirp = (nchirps_q != '0) &&
                          (chirp_idx_q == (nchirps_q - NCH_WIDTH'(1)));
`else
    assign w_nch_ok     = (cfg_nchirps != '0);
    assign w_last_chirp = (chirp_idx_q == (nchirps_q - NCH_WIDTH'(1)));
`endif

    assign w_cfg_ok     = (cfg_ramp_len >= CNT_WIDTH'(2)) && (cfg_idle_len != '0) &&
                          w_nch_ok && !err_nsmall;
    assign w_issued     = {1'b0, chirp_idx_q} + (NCH_WIDTH + 1)'(1);
    assign w_hs         = f_tvalid && f_tready && f_tlast;
    assign w_cnt_end    = (cnt_q == CNT_WIDTH'(1));
    assign w_busy       = (state_q != c_idle);
    assign w_drain_exit = ({1'b0, frames_q} >= w_issued) ||
                          (drain_cnt_q == c_drain_w'(DRAIN_MAX - 1));

    // State register and datapath flops.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= c_idle;
            cnt_q        <= '0;
            drain_cnt_q  <= '0;
            ramp_len_q   <= '0;
            idle_len_q   <= '0;
            nchirps_q    <= '0;
            nfft_q       <= '0;
            chirp_idx_q  <= '0;
            frames_q     <= '0;
            err_cfg_q    <= 1'b0;
            err_frames_q <= 1'b0;
            done_q       <= 1'b0;
            nsmall_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            ramp_len_q   <= ramp_len_d;
            idle_len_q   <= idle_len_d;
            nchirps_q    <= nchirps_d;
            nfft_q       <= nfft_d;
            chirp_idx_q  <= chirp_idx_d;
            frames_q     <= frames_d;
            err_cfg_q    <= err_cfg_d;
            err_frames_q <= err_frames_d;
            done_q       <= done_d;
            nsmall_q     <= nsmall_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle: begin
                if (start && w_cfg_ok) begin
                    state_d = c_ramp;
                end
            end
            c_ramp: begin
                if (stop) begin
                    state_d = c_drain;
                end else if (w_cnt_end) begin
                    state_d = c_gap;
                end
            end
            c_gap: begin
                if (stop) begin
                    state_d = c_drain;
                end else if (w_cnt_end) begin
                    state_d = w_last_chirp ? c_drain : c_ramp;
                end
            end
            c_drain: begin
                if (w_drain_exit) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    // Counters, latched configuration and error flags.
    always_comb begin
        cnt_d        = cnt_q;
        drain_cnt_d  = drain_cnt_q;
        ramp_len_d   = ramp_len_q;
        idle_len_d   = idle_len_q;
        nchirps_d    = nchirps_q;
        nfft_d       = nfft_q;
        chirp_idx_d  = chirp_idx_q;
        frames_d     = frames_q;
        err_cfg_d    = err_cfg_q;
        err_frames_d = err_frames_q;
        done_d       = 1'b0;
        nsmall_d     = err_nsmall;

        case (state_q)
            c_idle: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        ramp_len_d   = cfg_ramp_len;
                        idle_len_d   = cfg_idle_len;
                        nchirps_d    = cfg_nchirps;
                        nfft_d       = cfg_nfft_in;
                        cnt_d        = cfg_ramp_len;
                        chirp_idx_d  = '0;
                        frames_d     = '0;
                        err_cfg_d    = 1'b0;
                        err_frames_d = 1'b0;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            c_ramp: begin
                drain_cnt_d = '0;
                if (!stop) begin
                    cnt_d = w_cnt_end ? idle_len_q : (cnt_q - CNT_WIDTH'(1));
                end
            end
            c_gap: begin
                drain_cnt_d = '0;
                if (!stop) begin
                    if (w_cnt_end) begin
                        if (!w_last_chirp) begin
                            cnt_d       = ramp_len_q;
                            chirp_idx_d = chirp_idx_q + NCH_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            c_drain: begin
                drain_cnt_d = drain_cnt_q + c_drain_w'(1);
                if (w_drain_exit) begin
                    done_d = 1'b1;
                    if ({1'b0, frames_q} != w_issued) begin
                        err_frames_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Frame audit runs in every busy state, saturating at all-ones.
        if (w_busy && w_hs && (frames_q != {NCH_WIDTH{1'b1}})) begin
            frames_d = frames_q + NCH_WIDTH'(1);
        end
        if (w_busy && err_nsmall && !nsmall_q) begin
            err_frames_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        ramp       = (state_q == c_ramp);
        busy       = w_busy;
        done       = done_q;
        chirp_idx  = chirp_idx_q;
        frames     = frames_q;
        cfg_nfft   = nfft_q;
        err_cfg    = err_cfg_q;
        err_frames = err_frames_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_chirp_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_axis_chirp_sequencer                                      |
// | Description: Self-checking bench with a framer model and scoreboards for  |
// |              ramp-high lengths and end-of-burst results.                  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_axis_chirp_sequencer;

    localparam int CW = 24;
    localparam int NW = 16;
    localparam int DM = 64;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic          stop;
    logic [CW-1:0] cfg_ramp_len;
    logic [CW-1:0] cfg_idle_len;
    logic [NW-1:0] cfg_nchirps;
    logic [4:0]    cfg_nfft_in;
    logic [4:0]    cfg_nfft;
    logic          err_nsmall;
    logic          ramp;
    logic          f_tvalid;
    logic          f_tready;
    logic          f_tlast;
    logic          busy;
    logic          done;
    logic [NW-1:0] chirp_idx;
    logic [NW-1:0] frames;
    logic          err_cfg;
    logic          err_frames;

    axis_chirp_sequencer #(.CNT_WIDTH(CW), .NCH_WIDTH(NW), .DRAIN_MAX(DM)) dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop),
        .cfg_ramp_len(cfg_ramp_len), .cfg_idle_len(cfg_idle_len),
        .cfg_nchirps(cfg_nchirps), .cfg_nfft_in(cfg_nfft_in), .cfg_nfft(cfg_nfft),
        .err_nsmall(err_nsmall), .ramp(ramp),
        .f_tvalid(f_tvalid), .f_tready(f_tready), .f_tlast(f_tlast),
        .busy(busy), .done(done), .chirp_idx(chirp_idx), .frames(frames),
        .err_cfg(err_cfg), .err_frames(err_frames)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int ramp_len;
        int idle_len;
        int nchirps;
        int nfft;
        bit nsmall;
        bit accept;
    } vec_t;

    typedef struct {
        int frames;
        int chirp_idx;
        bit err_frames;
    } burst_t;

    int     exp_ramp_q[$];
    burst_t exp_done_q[$];
    int     n_checks    = 0;
    int     n_fail      = 0;
    int     run_len     = 0;
    int     pend        = 0;
    int     emit_budget = 1000;
    bit     prev_ramp   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Framer model: one tlast handshake two cycles after every ramp fall.
    always @(negedge aclk) begin
        f_tvalid = 1'b0;
        f_tlast  = 1'b0;
        if (areset === 1'b1) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    f_tvalid = 1'b1;
                    f_tlast  = 1'b1;
                end
            end
            if (prev_ramp && (ramp === 1'b0) && (emit_budget > 0)) begin
                pend = 2;
                emit_budget--;
            end
        end
        prev_ramp = (ramp === 1'b1);
    end

    // Ramp-high run-length scoreboard.
    always @(negedge aclk) begin
        if (areset === 1'b1) begin
            run_len = 0;
        end else if (ramp === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            if (exp_ramp_q.size() == 0) begin
                check("ramp_unexpected", 64'(run_len), 64'd0);
            end else begin
                check("ramp_high_len", 64'(run_len), 64'(exp_ramp_q.pop_front()));
            end
            run_len = 0;
        end
    end

    // End-of-burst scoreboard, popped on each done pulse.
    always @(negedge aclk) begin
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'd0);
            end else begin
                burst_t b;
                b = exp_done_q.pop_front();
                check("done_frames", 64'(frames), 64'(b.frames));
                check("done_chirp_idx", 64'(chirp_idx), 64'(b.chirp_idx));
                check("done_err_frames", 64'(err_frames), 64'(b.err_frames));
            end
        end
    end

    task automatic drive_start(input int r, input int i, input int n, input int f,
                               input bit nsmall, input bit with_stop);
        cfg_ramp_len = CW'(r);
        cfg_idle_len = CW'(i);
        cfg_nchirps  = NW'(n);
        cfg_nfft_in  = 5'(f);
        err_nsmall   = nsmall;
        start        = 1'b1;
        stop         = with_stop;
        @(negedge aclk);
        start        = 1'b0;
        stop         = 1'b0;
        err_nsmall   = 1'b0;
    endtask

    task automatic push_burst(input int ramp_len, input int nramps, input int fr,
                              input int idx, input bit errf);
        burst_t b;
        for (int k = 0; k < nramps; k++) exp_ramp_q.push_back(ramp_len);
        b.frames     = fr;
        b.chirp_idx  = idx;
        b.err_frames = errf;
        exp_done_q.push_back(b);
    endtask

    task automatic wait_idle(output int busy_cycles);
        bit ok;
        ok = 1'b0;
        busy_cycles = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge aclk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            busy_cycles++;
        end
        if (!ok) check("wait_idle_timeout", 64'(busy), 64'd0);
        @(negedge aclk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        int cyc;
        areset = 1'b1; start = 1'b0; stop = 1'b0; err_nsmall = 1'b0; f_tready = 1'b1;
        cfg_ramp_len = '0; cfg_idle_len = '0; cfg_nchirps = '0; cfg_nfft_in = '0;

        tbl[0] = '{8, 4, 3, 12, 1'b0, 1'b1};
        tbl[1] = '{1, 4, 3, 12, 1'b0, 1'b0};
        tbl[2] = '{8, 4, 2, 10, 1'b0, 1'b1};
        tbl[3] = '{2, 1, 1,  5, 1'b0, 1'b1};
        tbl[4] = '{4, 0, 2,  7, 1'b0, 1'b0};
`ifdef CHIRP_SEQ_CONTINUOUS_EN
        tbl[5] = '{4, 2, 1,  7, 1'b0, 1'b1};
`else
        tbl[5] = '{4, 2, 0,  7, 1'b0, 1'b0};
`endif
        tbl[6] = '{8, 4, 3,  3, 1'b1, 1'b0};
        tbl[7] = '{3, 2, 4,  9, 1'b0, 1'b1};

        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_ramp", 64'(ramp), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_chirp_idx", 64'(chirp_idx), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("rst_cfg_nfft", 64'(cfg_nfft), 64'd0);
        check("rst_err_cfg", 64'(err_cfg), 64'd0);
        check("rst_err_frames", 64'(err_frames), 64'd0);

        // Table-driven configurations.
        for (int v = 0; v < 8; v++) begin
            if (tbl[v].accept)
                push_burst(tbl[v].ramp_len, tbl[v].nchirps, tbl[v].nchirps, tbl[v].nchirps - 1, 1'b0);
            drive_start(tbl[v].ramp_len, tbl[v].idle_len, tbl[v].nchirps, tbl[v].nfft,
                        tbl[v].nsmall, 1'b0);
            check("start_busy", 64'(busy), 64'(tbl[v].accept));
            check("start_ramp", 64'(ramp), 64'(tbl[v].accept));
            check("start_err_cfg", 64'(err_cfg), 64'(!tbl[v].accept));
            if (tbl[v].accept) begin
                check("start_cfg_nfft", 64'(cfg_nfft), 64'(tbl[v].nfft));
                check("start_chirp_idx", 64'(chirp_idx), 64'd0);
                wait_idle(cyc);
            end else begin
                repeat (3) @(negedge aclk);
                check("reject_busy", 64'(busy), 64'd0);
            end
        end

        // Start and stop together in IDLE; start/cfg changes while busy; nsmall rise.
        push_burst(8, 2, 2, 1, 1'b1);
        drive_start(8, 4, 2, 6, 1'b0, 1'b1);
        check("startstop_busy", 64'(busy), 64'd1);
        check("startstop_ramp", 64'(ramp), 64'd1);
        repeat (3) @(negedge aclk);
        cfg_ramp_len = CW'(1);
        cfg_nfft_in  = 5'd9;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("busy_start_err_cfg", 64'(err_cfg), 64'd0);
        check("busy_cfg_nfft", 64'(cfg_nfft), 64'd6);
        err_nsmall = 1'b1;
        @(negedge aclk);
        err_nsmall = 1'b0;
        check("nsmall_err_frames", 64'(err_frames), 64'd1);
        check("nsmall_continues", 64'(busy), 64'd1);
        wait_idle(cyc);

        // Stop during the third ramp of a five-chirp burst.
        exp_ramp_q.push_back(8);
        exp_ramp_q.push_back(8);
        push_burst(3, 1, 3, 2, 1'b0);
        drive_start(8, 4, 5, 11, 1'b0, 1'b0);
        for (int k = 0; k < 500 && !(chirp_idx == 2 && ramp); k++) @(negedge aclk);
        check("t3_reach_third", 64'(chirp_idx == 2 && ramp), 64'd1);
        repeat (2) @(negedge aclk);
        stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        check("stop_ramp_low", 64'(ramp), 64'd0);
        check("stop_drain_busy", 64'(busy), 64'd1);
        wait_idle(cyc);

        // Missing frame: drain times out.
        emit_budget = 1;
        push_burst(8, 2, 1, 1, 1'b1);
        drive_start(8, 4, 2, 4, 1'b0, 1'b0);
        wait_idle(cyc);
        check("drain_timeout_cycles", 64'(cyc), 64'(2 * (8 + 4) + DM));
        emit_budget = 1000;

        // Reset mid-GAP of chirp 2, then a fresh burst.
        exp_ramp_q.push_back(8);
        exp_ramp_q.push_back(8);
        drive_start(8, 4, 3, 13, 1'b0, 1'b0);
        for (int k = 0; k < 500 && !(chirp_idx == 1 && !ramp && busy); k++) @(negedge aclk);
        check("t5_reach_gap2", 64'(chirp_idx == 1 && !ramp && busy), 64'd1);
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("arst_ramp", 64'(ramp), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_chirp_idx", 64'(chirp_idx), 64'd0);
        check("arst_frames", 64'(frames), 64'd0);
        check("arst_cfg_nfft", 64'(cfg_nfft), 64'd0);
        check("arst_err_frames", 64'(err_frames), 64'd0);
        check("arst_ramp_q", 64'(exp_ramp_q.size()), 64'd0);
        repeat (4) @(negedge aclk);
        push_burst(8, 3, 3, 2, 1'b0);
        drive_start(8, 4, 3, 12, 1'b0, 1'b0);
        check("fresh_busy", 64'(busy), 64'd1);
        wait_idle(cyc);

`ifdef CHIRP_SEQ_CONTINUOUS_EN
        // Free-running burst stopped during the tenth ramp.
        for (int k = 0; k < 9; k++) exp_ramp_q.push_back(4);
        push_burst(1, 1, 10, 9, 1'b0);
        drive_start(4, 3, 0, 8, 1'b0, 1'b0);
        check("cont_accept", 64'(busy), 64'd1);
        for (int k = 0; k < 1000 && !(chirp_idx == 9 && ramp); k++) @(negedge aclk);
        check("cont_reach_tenth", 64'(chirp_idx == 9 && ramp), 64'd1);
        stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        check("cont_stop_ramp", 64'(ramp), 64'd0);
        wait_idle(cyc);
`endif

        repeat (4) @(negedge aclk);
        check("ramp_q_empty", 64'(exp_ramp_q.size()), 64'd0);
        check("done_q_empty", 64'(exp_done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
